// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control unit and datapath blocks.
package sisc_pkg;

  localparam int unsigned OP_NOOP = 0;
  localparam int unsigned OP_LOD  = 1;
  localparam int unsigned OP_STR  = 2;
  localparam int unsigned OP_SWP  = 3;
  localparam int unsigned OP_BRA  = 4;
  localparam int unsigned OP_BRR  = 5;
  localparam int unsigned OP_BNE  = 6;
  localparam int unsigned OP_BNR  = 7;
  localparam int unsigned OP_ALU  = 8;
  localparam int unsigned OP_HLT  = 15;

  localparam int unsigned MM_IMM  = 8;

  localparam int unsigned ALU_REG = 0;
  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SWP = 2;

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_e;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation: masked status test and relative-target select.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  output logic           taken,
  output logic           rel
);

  logic any_set;

  always_comb begin
    any_set = |(mm & stat);
    taken   = 1'b0;
    rel     = 1'b0;
    if (opcode == OPW'(OP_BRA) || opcode == OPW'(OP_BRR)) begin
      taken = any_set;
    end else if (opcode == OPW'(OP_BNE) || opcode == OPW'(OP_BNR)) begin
      taken = ~any_set;
    end
    rel = (opcode == OPW'(OP_BRR)) || (opcode == OPW'(OP_BNR));
  end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle SISC control FSM; all outputs decoded combinationally from state and inputs.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int MMW  = 4,
  parameter int ALUW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [MMW-1:0]  mm,
  input  logic [MMW-1:0]  stat,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            br_sel,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [ALUW-1:0] alu_op,
  output logic            mem_req,
  output logic            dm_we,
  output logic            halted
);

  state_e state_q, state_d;
  logic   br_taken, br_rel;
  logic   is_lod, is_str, is_swp, is_alu, is_hlt, is_mem_op, is_alu_op;
  logic   [ALUW-1:0] alu_sel;

  sisc_br_cond #(.OPW(OPW), .MMW(MMW)) u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken),
    .rel    (br_rel)
  );

  always_comb begin
    is_lod    = (opcode == OPW'(OP_LOD));
    is_str    = (opcode == OPW'(OP_STR));
    is_swp    = (opcode == OPW'(OP_SWP));
    is_alu    = (opcode == OPW'(OP_ALU));
    is_hlt    = (opcode == OPW'(OP_HLT));
    is_mem_op = is_lod | is_str;
    is_alu_op = is_alu | is_swp;
    alu_sel   = '0;
    if (is_alu && mm == MMW'(MM_IMM)) alu_sel = ALUW'(ALU_ADD);
    else if (is_alu)                  alu_sel = ALUW'(ALU_REG);
    else if (is_mem_op)               alu_sel = ALUW'(ALU_ADD);
    else if (is_swp)                  alu_sel = ALUW'(ALU_SWP);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_START1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_hlt)                      state_d = S_HALT;
        else if (is_mem_op || is_alu_op) state_d = S_EXECUTE;
        else                             state_d = S_FETCH;
      end
      S_EXECUTE: begin
        if (is_mem_op)      state_d = S_MEM;
        else if (is_alu_op) state_d = S_WRITEBACK;
        else                state_d = S_FETCH;
      end
      S_MEM:       if (mem_ready) state_d = is_lod ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  // Outputs are forced low while rst is high so a reset mid-store cannot pulse dm_we.
  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = '0;
    mem_req  = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
            br_sel   = br_rel;
          end
        end
        S_EXECUTE: alu_op = alu_sel;
        S_MEM: begin
          alu_op  = alu_sel;
          mem_req = 1'b1;
          dm_we   = is_str & mem_ready;
        end
        S_WRITEBACK: begin
          alu_op = alu_sel;
          rf_we  = 1'b1;
          wb_sel = is_lod;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed self-checking bench for sisc_ctrl_mc.
module tb_sisc_ctrl_mc;
  import sisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode, mm, stat;
  logic       mem_ready;
  logic       ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, mem_req, dm_we, halted;
  logic [1:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  sisc_ctrl_mc #(.OPW(4), .MMW(4), .ALUW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .mem_ready (mem_ready),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .mem_req   (mem_req),
    .dm_we     (dm_we),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Packed view {ir,pw,ps,bs,we,wb,alu[1:0],mr,dw,h}
  function automatic int outs();
    return int'({ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, alu_op, mem_req, dm_we, halted});
  endfunction

  function automatic int eo(input bit ir, input bit pw, input bit ps, input bit bs, input bit we,
                            input bit wb, input bit [1:0] alu, input bit mr, input bit dw, input bit h);
    return int'({ir, pw, ps, bs, we, wb, alu, mr, dw, h});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int st();
    return int'(dut.state_q);
  endfunction

  initial begin
    rst = 1'b1; opcode = 4'(OP_NOOP); mm = '0; stat = '0; mem_ready = 1'b1;
    tick();
    check("rst_state", st(), int'(S_START1));
    check("rst_outs", outs(), 0);
    rst = 1'b0; #1;
    check("start1_outs", outs(), 0);

    // NOOP loop with mem_ready tied high
    tick();
    check("noop_fetch_st", st(), int'(S_FETCH));
    check("noop_fetch_o", outs(), eo(1,1,0,0,0,0,0,1,0,0));
    tick();
    check("noop_dec_st", st(), int'(S_DECODE));
    check("noop_dec_o", outs(), 0);
    tick();
    check("noop_fetch2_st", st(), int'(S_FETCH));
    check("noop_fetch2_o", outs(), eo(1,1,0,0,0,0,0,1,0,0));

    // ALU immediate
    opcode = 4'(OP_ALU); mm = 4'd8;
    tick();
    check("alu_dec_o", outs(), 0);
    tick();
    check("alu_ex_st", st(), int'(S_EXECUTE));
    check("alu_ex_o", outs(), eo(0,0,0,0,0,0,1,0,0,0));
    tick();
    check("alu_wb_st", st(), int'(S_WRITEBACK));
    check("alu_wb_o", outs(), eo(0,0,0,0,1,0,1,0,0,0));
    tick();
    check("alu_back_st", st(), int'(S_FETCH));

    // SWP uses alu_op 2
    opcode = 4'(OP_SWP); mm = 4'd0;
    tick(); tick();
    check("swp_ex_o", outs(), eo(0,0,0,0,0,0,2,0,0,0));
    tick();
    check("swp_wb_o", outs(), eo(0,0,0,0,1,0,2,0,0,0));
    tick();

    // LOD with three wait cycles in MEM
    opcode = 4'(OP_LOD); mm = 4'd0;
    tick();
    mem_ready = 1'b0;
    tick();
    check("lod_ex_o", outs(), eo(0,0,0,0,0,0,1,0,0,0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lod_mem_wait_st", st(), int'(S_MEM));
      check("lod_mem_req", int'(mem_req), 1);
      check("lod_mem_we", int'(rf_we | dm_we), 0);
    end
    mem_ready = 1'b1; #1;
    check("lod_mem4_st", st(), int'(S_MEM));
    check("lod_mem4_dw", int'(dm_we), 0);
    tick();
    check("lod_wb_st", st(), int'(S_WRITEBACK));
    check("lod_wb_o", outs(), eo(0,0,0,0,1,1,1,0,0,0));
    tick();

    // BRR taken, then not taken
    opcode = 4'(OP_BRR); mm = 4'b0010; stat = 4'b0010;
    tick();
    check("brr_t_o", outs(), eo(0,1,1,1,0,0,0,0,0,0));
    tick();
    stat = 4'b0001;
    tick();
    check("brr_nt_pw", int'(pc_write), 0);
    check("brr_nt_o", outs(), 0);
    tick();

    // BNE with mm=0 always taken, absolute target
    opcode = 4'(OP_BNE); mm = 4'b0000; stat = 4'b1111;
    tick();
    check("bne_mm0_o", outs(), eo(0,1,1,0,0,0,0,0,0,0));
    tick();
    // BRA with mm=0 never taken
    opcode = 4'(OP_BRA);
    tick();
    check("bra_mm0_o", outs(), 0);
    tick();
    // Undefined opcode behaves as NOOP
    opcode = 4'd11;
    tick();
    tick();
    check("undef_st", st(), int'(S_FETCH));

    // STR completing normally
    opcode = 4'(OP_STR); stat = '0;
    tick(); tick();
    tick();
    check("str_mem_o", outs(), eo(0,0,0,0,0,0,1,1,1,0));
    tick();
    check("str_back_st", st(), int'(S_FETCH));

    // STR with reset in MEM
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    check("strr_mem_st", st(), int'(S_MEM));
    check("strr_mem_dw", int'(dm_we), 0);
    mem_ready = 1'b1; rst = 1'b1; #1;
    check("strr_rst_o", outs(), 0);
    tick();
    check("strr_st", st(), int'(S_START1));
    check("strr_after_o", outs(), 0);
    rst = 1'b0;

    // FETCH waits on mem_ready
    mem_ready = 1'b0;
    tick();
    check("fetch_wait_o", outs(), eo(0,0,0,0,0,0,0,1,0,0));
    tick();
    check("fetch_wait_st", st(), int'(S_FETCH));
    mem_ready = 1'b1;

    // HLT is absorbing until reset
    opcode = 4'(OP_HLT);
    tick(); tick();
    check("hlt_st", st(), int'(S_HALT));
    check("hlt_o", outs(), eo(0,0,0,0,0,0,0,0,0,1));
    opcode = 4'(OP_ALU);
    tick(); tick();
    check("hlt_hold_st", st(), int'(S_HALT));
    check("hlt_hold_o", outs(), eo(0,0,0,0,0,0,0,0,0,1));
    rst = 1'b1;
    tick();
    check("hlt_rst_st", st(), int'(S_START1));
    check("hlt_rst_h", int'(halted), 0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
